// File: rtl/sar_adc_pkg.sv
// Shared types and real-valued helpers for the successive-approximation ADC model.
package sar_adc_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      for (int i = 0; i < n; i++) begin
         r = r * 2.0;
      end
      return r;
   endfunction

   function automatic real lsb(input real vref, input int n);
      return vref / pow2(n);
   endfunction

   function automatic real clamp(input real v, input real lo, input real hi);
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/sar_dac.sv
// Combinational real-valued binary DAC: vout = (code - offset) * vref / 2**N,
// with an optional half-LSB downward offset for round-to-nearest thresholds.
module sar_dac
   import sar_adc_pkg::*;
#(
   parameter int N        = 3,
   parameter bit HALF_LSB = 1'b0
) (
   input  logic [N-1:0] code_i,
   input  real          vref_i,
   output real          vout_o
);

   // Threshold voltage for the current trial code.
   always_comb begin
      vout_o = (real'(code_i) - (HALF_LSB ? 0.5 : 0.0)) * lsb(vref_i, N);
   end

endmodule

// File: rtl/sar_adc.sv
// N-bit SAR ADC: sample/hold on start, one bit per clock MSB-first, registered result.
// Optional macro SAR_ADC_ROUND_EN shifts DAC thresholds by -LSB/2 (round-to-nearest).
module sar_adc
   import sar_adc_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  real          vin_i,
   input  real          vref_i,
   output logic [N-1:0] q_o,
   output logic         valid_o,
   output logic         busy_o,
   output logic         ovr_o
);

`ifdef SAR_ADC_ROUND_EN
   localparam bit HalfLsb = 1'b1;
`else
   localparam bit HalfLsb = 1'b0;
`endif

   localparam logic [N-1:0] MsbMask = N'(1'b1) << (N - 1);

   state_e       state_q, state_d;
   logic [N-1:0] code_q, code_d;
   logic [N-1:0] mask_q, mask_d;
   logic [N-1:0] res_s;
   real          vh_q, vh_d;
   real          vr_q, vr_d;
   logic         ovrn_q, ovrn_d;
   logic [N-1:0] q_q, q_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         ovr_q, ovr_d;
   real          vdac_s;

   sar_dac #(
      .N        (N),
      .HALF_LSB (HalfLsb)
   ) u_dac (
      .code_i (code_q),
      .vref_i (vr_q),
      .vout_o (vdac_s)
   );

   // Next-state, sample/hold, SAR register and output logic.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      mask_d  = mask_q;
      vh_d    = vh_q;
      vr_d    = vr_q;
      ovrn_d  = ovrn_q;
      q_d     = q_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q;
      res_s   = code_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               vh_d    = clamp(vin_i, 0.0, vref_i);
               vr_d    = vref_i;
               ovrn_d  = (vin_i < 0.0) || (vin_i > vref_i);
               code_d  = MsbMask;
               mask_d  = MsbMask;
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            // mask_q marks the bit under trial; bit 0 under trial means last step.
            if (vh_q >= vdac_s) begin
               res_s = code_q;
            end else begin
               res_s = code_q & ~mask_q;
            end
            if (mask_q[0]) begin
               q_d     = res_s;
               ovr_d   = ovrn_q;
               valid_d = 1'b1;
               code_d  = res_s;
               mask_d  = '0;
               state_d = IDLE;
            end else begin
               mask_d  = mask_q >> 1;
               code_d  = res_s | (mask_q >> 1);
               state_d = CONV;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == CONV);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         code_q  <= '0;
         mask_q  <= '0;
         vh_q    <= 0.0;
         vr_q    <= 0.0;
         ovrn_q  <= 1'b0;
         q_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         mask_q  <= mask_d;
         vh_q    <= vh_d;
         vr_q    <= vr_d;
         ovrn_q  <= ovrn_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign q_o     = q_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign ovr_o   = ovr_q;

endmodule
